fault_resp_compactor: RTL and testbench

- Response-side counterpart of the batch fault-injection controller.
- The injection side selects a fault ID, drives one stimulus pass and emits one response word per vector. This block consumes that response stream per pass.
- It compacts the stream into a MISR signature, holds the golden (fault-free) signature, and reports one detected/undetected verdict per fault ID.
- It sits between the gate-netlist DUT output bus and the fault-ranking result sink, so that campaigns need no per-cycle text dumps.

---
 rtl/fault_resp_pkg.sv | 28 ++
 rtl/fault_resp_compactor_if.sv | 34 +++
 rtl/fault_misr.sv | 34 +++
 rtl/fault_resp_compactor.sv | 180 ++++++++++++++++++
 tb/tb_fault_resp_compactor.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fault_resp_pkg.sv
// Shared types and MISR helpers for the fault response compactor.
package fault_resp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_e;

    localparam int unsigned    SIG_MAX  = 64;
    localparam logic [SIG_MAX-1:0] SIG_SEED = '1;
    localparam logic [31:0]    POLY_DEF = 32'h04C11DB7;

    // Width-generic MISR step: the signature lives in the low `width` bits.
    function automatic logic [SIG_MAX-1:0] misr_next(
        input logic [SIG_MAX-1:0] sig,
        input logic [SIG_MAX-1:0] data,
        input logic [SIG_MAX-1:0] poly,
        input int unsigned        width
    );
        logic [SIG_MAX-1:0] mask;
        logic [SIG_MAX-1:0] msb_vec;
        mask    = (width >= SIG_MAX) ? '1 : ((SIG_MAX'(1) << width) - SIG_MAX'(1));
        msb_vec = sig >> (width - 1);
        misr_next = ((sig << 1) ^ (msb_vec[0] ? poly : '0) ^ data) & mask;
    endfunction

endpackage

// File: rtl/fault_resp_compactor_if.sv
// Pass-start, response-stream and verdict signals of the fault response compactor.
interface fault_resp_compactor_if #(
    parameter int RESP_W = 26,
    parameter int FID_W  = 16,
    parameter int SIG_W  = 32,
    parameter int CNT_W  = 9
);
    logic              pass_start;
    logic [FID_W-1:0]  pass_fid;
    logic              pass_golden;
    logic              resp_valid;
    logic [RESP_W-1:0] resp_data;
    logic              resp_ready;
    logic              res_valid;
    logic              res_ready;
    logic [FID_W-1:0]  res_fid;
    logic              res_golden;
    logic              res_detected;
    logic              res_no_golden;
    logic [SIG_W-1:0]  res_sig;
    logic [CNT_W-1:0]  res_first_cyc;

    modport slave (
        input  pass_start, pass_fid, pass_golden, resp_valid, resp_data, res_ready,
        output resp_ready, res_valid, res_fid, res_golden, res_detected,
               res_no_golden, res_sig, res_first_cyc
    );

    modport master (
        output pass_start, pass_fid, pass_golden, resp_valid, resp_data, res_ready,
        input  resp_ready, res_valid, res_fid, res_golden, res_detected,
               res_no_golden, res_sig, res_first_cyc
    );
endinterface

// File: rtl/fault_misr.sv
// Signature register with synchronous clear (to SIG_SEED) and per-word enable.
module fault_misr
    import fault_resp_pkg::*;
#(
    parameter int               RESP_W = 26,
    parameter int               SIG_W  = 32,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [RESP_W-1:0] data,
    output logic [SIG_W-1:0]  sig,
    output logic [SIG_W-1:0]  sig_upd
);
    logic [SIG_W-1:0] sig_q, sig_d;

    assign sig_upd = SIG_W'(misr_next(SIG_MAX'(sig_q), SIG_MAX'(data), SIG_MAX'(POLY), SIG_W));

    always_comb begin
        sig_d = sig_q;
        if (clr)     sig_d = SIG_W'(SIG_SEED);
        else if (en) sig_d = sig_upd;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= SIG_W'(SIG_SEED);
        else        sig_q <= sig_d;
    end

    assign sig = sig_q;
endmodule

// File: rtl/fault_resp_compactor.sv
// Compacts one response pass into a MISR signature and emits a detected/undetected verdict.
// Optional FAULT_RESP_FIRST_DIFF_EN adds a golden word memory and first-differing-word index.
module fault_resp_compactor
    import fault_resp_pkg::*;
#(
    parameter int               RESP_W = 26,
    parameter int               CYCLES = 512,
    parameter int               FID_W  = 16,
    parameter int               SIG_W  = 32,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_DEF)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fault_resp_compactor_if.slave  bus,
    output logic                   busy,
    output logic                   err_overrun
);
    localparam int CNT_W = $clog2(CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    state_e            state_q, state_d;
    logic [FID_W-1:0]  fid_q, fid_d, res_fid_q, res_fid_d;
    logic              golden_q, golden_d, golden_valid_q, golden_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SIG_W-1:0]  golden_sig_q, golden_sig_d, res_sig_q, res_sig_d;
    logic              res_valid_q, res_valid_d, res_golden_q, res_golden_d;
    logic              res_detected_q, res_detected_d, res_no_golden_q, res_no_golden_d;
    logic              err_q, err_d;
    logic              hs, misr_clr, diff_any;
    logic [SIG_W-1:0]  sig_cur, sig_upd;

    assign hs = (state_q == COLLECT) && bus.resp_valid;

    fault_misr #(.RESP_W(RESP_W), .SIG_W(SIG_W), .POLY(POLY)) u_misr (
        .clk(clk), .rst_n(rst_n), .clr(misr_clr), .en(hs),
        .data(bus.resp_data), .sig(sig_cur), .sig_upd(sig_upd)
    );

`ifdef FAULT_RESP_FIRST_DIFF_EN
    logic [RESP_W-1:0] golden_mem [CYCLES];
    logic              diff_seen_q, diff_seen_d;
    logic [CNT_W-1:0]  first_q, first_d;
    logic              word_diff;

    assign word_diff = hs && !golden_q && golden_valid_q && (golden_mem[cnt_q] != bus.resp_data);

    // NOTE: the golden memory has no reset; golden_valid_q gates every read of it.
    always_ff @(posedge clk) begin
        if (hs && golden_q) golden_mem[cnt_q] <= bus.resp_data;
    end

    always_comb begin
        diff_seen_d = diff_seen_q;
        first_d     = first_q;
        if (state_q == IDLE && bus.pass_start) begin
            diff_seen_d = 1'b0;
            first_d     = '1;
        end else if (word_diff && !diff_seen_q) begin
            diff_seen_d = 1'b1;
            first_d     = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_seen_q <= 1'b0;
            first_q     <= '1;
        end else begin
            diff_seen_q <= diff_seen_d;
            first_q     <= first_d;
        end
    end

    assign diff_any          = diff_seen_d;
    assign bus.res_first_cyc = first_q;
`else
    assign diff_any          = 1'b0;
    assign bus.res_first_cyc = '1;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d         = state_q;
        fid_d           = fid_q;
        golden_d        = golden_q;
        cnt_d           = cnt_q;
        golden_sig_d    = golden_sig_q;
        golden_valid_d  = golden_valid_q;
        res_valid_d     = res_valid_q;
        res_fid_d       = res_fid_q;
        res_golden_d    = res_golden_q;
        res_detected_d  = res_detected_q;
        res_no_golden_d = res_no_golden_q;
        res_sig_d       = res_sig_q;
        err_d           = err_q;
        misr_clr        = 1'b0;
        unique case (state_q)
            IDLE: if (bus.pass_start) begin
                fid_d    = bus.pass_fid;
                golden_d = bus.pass_golden;
                cnt_d    = '0;
                misr_clr = 1'b1;
                state_d  = COLLECT;
            end
            COLLECT: if (hs) begin
                if (cnt_q == CNT_LAST) begin
                    state_d         = REPORT;
                    res_valid_d     = 1'b1;
                    res_fid_d       = fid_q;
                    res_golden_d    = golden_q;
                    res_sig_d       = sig_upd;
                    res_detected_d  = 1'b0;
                    res_no_golden_d = 1'b0;
                    if (golden_q) begin
                        golden_sig_d   = sig_upd;
                        golden_valid_d = 1'b1;
                    end else if (golden_valid_q) begin
                        res_detected_d = (sig_upd != golden_sig_q) || diff_any;
                    end else begin
                        res_no_golden_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPORT: if (bus.res_ready) begin
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.pass_start && state_q != IDLE) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            fid_q           <= '0;
            golden_q        <= 1'b0;
            cnt_q           <= '0;
            golden_sig_q    <= '0;
            golden_valid_q  <= 1'b0;
            res_valid_q     <= 1'b0;
            res_fid_q       <= '0;
            res_golden_q    <= 1'b0;
            res_detected_q  <= 1'b0;
            res_no_golden_q <= 1'b0;
            res_sig_q       <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            fid_q           <= fid_d;
            golden_q        <= golden_d;
            cnt_q           <= cnt_d;
            golden_sig_q    <= golden_sig_d;
            golden_valid_q  <= golden_valid_d;
            res_valid_q     <= res_valid_d;
            res_fid_q       <= res_fid_d;
            res_golden_q    <= res_golden_d;
            res_detected_q  <= res_detected_d;
            res_no_golden_q <= res_no_golden_d;
            res_sig_q       <= res_sig_d;
            err_q           <= err_d;
        end
    end

    assign bus.resp_ready    = (state_q == COLLECT);
    assign bus.res_valid     = res_valid_q;
    assign bus.res_fid       = res_fid_q;
    assign bus.res_golden    = res_golden_q;
    assign bus.res_detected  = res_detected_q;
    assign bus.res_no_golden = res_no_golden_q;
    assign bus.res_sig       = res_sig_q;
    assign busy              = (state_q != IDLE);
    assign err_overrun       = err_q;

    // The live signature is only observed through the registered res_sig.
    logic unused_sig;
    assign unused_sig = ^sig_cur;
endmodule

// File: tb/tb_fault_resp_compactor.sv
// Directed bench for fault_resp_compactor with CYCLES=4; signatures hand-computed for POLY 04C11DB7.
module tb_fault_resp_compactor;
    localparam int RESP_W = 26;
    localparam int CYCLES = 4;
    localparam int FID_W  = 16;
    localparam int SIG_W  = 32;
    localparam int CNT_W  = 2;

    // Seed FFFFFFFF -> FB3EE249 -> F2BCD925 -> E579B24A^POLY (^1 for S1) -> final.
    localparam logic [SIG_W-1:0] S0   = 32'hC7B0424D;
    localparam logic [SIG_W-1:0] S1   = 32'hC7B0424F;
    localparam logic [CNT_W-1:0] NONE = 2'd3;
`ifdef FAULT_RESP_FIRST_DIFF_EN
    localparam logic [CNT_W-1:0] FIRST7 = 2'd2;
`else
    localparam logic [CNT_W-1:0] FIRST7 = 2'd3;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err_overrun;
    int   n_cmp = 0;
    int   n_bad = 0;

    fault_resp_compactor_if #(.RESP_W(RESP_W), .FID_W(FID_W), .SIG_W(SIG_W), .CNT_W(CNT_W)) bus ();

    fault_resp_compactor #(.RESP_W(RESP_W), .CYCLES(CYCLES), .FID_W(FID_W), .SIG_W(SIG_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input logic [FID_W-1:0] fid, input logic golden);
        bus.pass_start  = 1'b1;
        bus.pass_fid    = fid;
        bus.pass_golden = golden;
        tick();
        bus.pass_start  = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic send_word(input logic [RESP_W-1:0] w);
        bus.resp_valid = 1'b1;
        bus.resp_data  = w;
        check("resp_ready_collect", bus.resp_ready, 1);
        tick();
        bus.resp_valid = 1'b0;
    endtask

    task automatic expect_verdict(input string tag, input logic [FID_W-1:0] fid, input logic golden,
                                  input logic det, input logic nog, input logic [SIG_W-1:0] sig,
                                  input logic [CNT_W-1:0] first);
        check({tag, ".valid"},     bus.res_valid, 1);
        check({tag, ".fid"},       bus.res_fid, fid);
        check({tag, ".golden"},    bus.res_golden, golden);
        check({tag, ".detected"},  bus.res_detected, det);
        check({tag, ".no_golden"}, bus.res_no_golden, nog);
        check({tag, ".sig"},       bus.res_sig, sig);
        check({tag, ".first_cyc"}, bus.res_first_cyc, first);
        check({tag, ".resp_ready"}, bus.resp_ready, 0);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check({tag, ".valid_clear"}, bus.res_valid, 0);
        check({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.pass_start  = 1'b0;
        bus.pass_fid    = '0;
        bus.pass_golden = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_data   = '0;
        bus.res_ready   = 1'b0;

        // Reset state
        #2;
        check("rst.busy",       busy, 0);
        check("rst.err",        err_overrun, 0);
        check("rst.resp_ready", bus.resp_ready, 0);
        check("rst.res_valid",  bus.res_valid, 0);
        check("rst.res_sig",    bus.res_sig, 0);
        check("rst.res_fid",    bus.res_fid, 0);
        check("rst.detected",   bus.res_detected, 0);
        check("rst.first_cyc",  bus.res_first_cyc, NONE);
        #15 rst_n = 1'b1;
        tick();

        // Fault pass before any golden pass
        start_pass(16'd3, 1'b0);
        for (int i = 0; i < CYCLES; i++) send_word('0);
        expect_verdict("nogold3", 16'd3, 1'b0, 1'b0, 1'b1, S0, NONE);

        // Golden pass
        start_pass(16'd1, 1'b1);
        for (int i = 0; i < CYCLES; i++) send_word('0);
        expect_verdict("golden", 16'd1, 1'b1, 1'b0, 1'b0, S0, NONE);

        // Fault pass matching golden
        start_pass(16'd5, 1'b0);
        for (int i = 0; i < CYCLES; i++) send_word('0);
        expect_verdict("match5", 16'd5, 1'b0, 1'b0, 1'b0, S0, NONE);

        // Fault pass with one flipped bit in word 2, then backpressure hold
        start_pass(16'd7, 1'b0);
        send_word('0);
        send_word('0);
        send_word(26'h000001);
        send_word('0);
        for (int i = 0; i < 10; i++) begin
            bus.resp_valid = 1'b1;
            bus.resp_data  = 26'h3FFFFFF;
            tick();
            check("hold.resp_ready", bus.resp_ready, 0);
            check("hold.valid",      bus.res_valid, 1);
            check("hold.sig",        bus.res_sig, S1);
            check("hold.detected",   bus.res_detected, 1);
        end
        bus.resp_valid = 1'b0;
        expect_verdict("diff7", 16'd7, 1'b0, 1'b1, 1'b0, S1, FIRST7);

        // Overrun during COLLECT
        check("pre_overrun.err", err_overrun, 0);
        start_pass(16'd9, 1'b0);
        send_word('0);
        send_word('0);
        bus.pass_start  = 1'b1;
        bus.pass_fid    = 16'd12;
        bus.pass_golden = 1'b1;
        tick();
        bus.pass_start  = 1'b0;
        check("overrun.err",  err_overrun, 1);
        check("overrun.busy", busy, 1);
        send_word('0);
        send_word('0);
        expect_verdict("overrun9", 16'd9, 1'b0, 1'b0, 1'b0, S0, NONE);
        check("overrun.sticky", err_overrun, 1);

        // Reset in the middle of a pass
        start_pass(16'd4, 1'b0);
        send_word('0);
        send_word('0);
        rst_n = 1'b0;
        #1;
        check("midrst.busy",       busy, 0);
        check("midrst.res_valid",  bus.res_valid, 0);
        check("midrst.resp_ready", bus.resp_ready, 0);
        check("midrst.err",        err_overrun, 0);
        check("midrst.first_cyc",  bus.res_first_cyc, NONE);
        #3 rst_n = 1'b1;
        tick();
        start_pass(16'd6, 1'b0);
        for (int i = 0; i < CYCLES; i++) send_word('0);
        expect_verdict("postrst6", 16'd6, 1'b0, 1'b0, 1'b1, S0, NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
